v_addsub_arbiter: RTL

Round-robin scheduler that shares one unsigned WIDTH-bit adder/subtractor among NREQ requesters. It sits between several client blocks and a single shared add/sub datapath. Each client posts operands and an add/subtract select under a REQ/ACK handshake. The block grants one client per cycle, registers that client's operands, and returns a registered result tagged with the client index, plus a carry/borrow flag.

---
 rtl/v_addsub_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/v_addsub_arbiter.sv
// Round-robin arbiter sharing one unsigned add/sub datapath among NREQ clients.
// Stage 1 grants and captures operands; stage 2 computes and tags the result.
module v_addsub_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                    C,
    input  logic                    CLR,
    input  logic [NREQ-1:0]         REQ,
    input  logic [NREQ-1:0]         ADDSUB,
    input  logic [NREQ*WIDTH-1:0]   A_BUS,
    input  logic [NREQ*WIDTH-1:0]   B_BUS,
    output logic [NREQ-1:0]         ACK,
    output logic [WIDTH-1:0]        RES,
    output logic                    CARRY,
    output logic [IDW-1:0]          RES_ID,
    output logic                    RES_VLD
);

    // Returns {carry_or_borrow, result}; subtraction reports borrow (A < B).
    function automatic logic [WIDTH:0] addsub_f(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sub);
        logic [WIDTH:0] s;
        if (sub) begin
            s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            s[WIDTH] = ~s[WIDTH];
        end else begin
            s = {1'b0, a} + {1'b0, b};
        end
        return s;
    endfunction

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  ack_q;
    logic             opvld_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sub_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [IDW-1:0]   resid_q;
    logic             resvld_q;

    logic [NREQ-1:0]  elig;
    logic             grant;
    logic [IDW-1:0]   win;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             sub_sel;

    // A client acknowledged this cycle is masked so a held REQ is not captured twice.
    assign elig = REQ & ~ack_q;

    always_comb begin
        logic [IDW-1:0] idx;
        grant   = 1'b0;
        win     = '0;
        idx     = '0;
        a_sel   = '0;
        b_sel   = '0;
        sub_sel = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant && elig[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                a_sel   = A_BUS[i*WIDTH +: WIDTH];
                b_sel   = B_BUS[i*WIDTH +: WIDTH];
                sub_sel = ADDSUB[i];
            end
        end
        ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    end

    // Stage 1: grant edge
    always_ff @(posedge C or negedge CLR) begin
        if (!CLR) begin
            ptr_q   <= '0;
            ack_q   <= '0;
            opvld_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            opvld_q <= grant;
            ack_q   <= grant ? (NREQ'(1) << win) : '0;
            if (grant) begin
                ptr_q <= ptr_d;
                a_q   <= a_sel;
                b_q   <= b_sel;
                sub_q <= sub_sel;
                id_q  <= win;
            end
        end
    end

    // Stage 2: execute edge
    always_ff @(posedge C or negedge CLR) begin
        if (!CLR) begin
            res_q    <= '0;
            carry_q  <= 1'b0;
            resid_q  <= '0;
            resvld_q <= 1'b0;
        end else begin
            resvld_q <= opvld_q;
            if (opvld_q) begin
                {carry_q, res_q} <= addsub_f(a_q, b_q, sub_q);
                resid_q          <= id_q;
            end
        end
    end

    assign ACK     = ack_q;
    assign RES     = res_q;
    assign CARRY   = carry_q;
    assign RES_ID  = resid_q;
    assign RES_VLD = resvld_q;

endmodule
